// File: rtl/pulse_width_decoder.sv
// Pulse-width serial decoder.
// A high pulse near SHORT_NOMINAL cycles encodes a 0 and one near LONG_NOMINAL encodes a 1.
// Bits assemble MSB-first into words, which are handed out over a valid/ready handshake.
// Rejected pulses and idle-aborted partial words each raise a one-cycle flag.
// A completed word that arrives while the previous one is still unconsumed is dropped,
// and that sets a sticky overrun flag.

module pulse_width_decoder #(
    parameter int unsigned TIMER_WIDTH   = 8,
    parameter int unsigned SHORT_NOMINAL = 9,
    parameter int unsigned LONG_NOMINAL  = 18,
    parameter int unsigned TOLERANCE     = 4,
    parameter int unsigned WORD_BITS     = 8,
    parameter int unsigned IDLE_TIMEOUT  = 64,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         digital_in,
    output logic [WORD_BITS-1:0]         word_data,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [$clog2(WORD_BITS):0]   bit_count,
    output logic                         pulse_error,
    output logic                         timeout,
    output logic                         overrun
);

    localparam int unsigned BC_W = $clog2(WORD_BITS) + 1;

    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = '1;
    localparam logic [TIMER_WIDTH-1:0] SHORT_T   = TIMER_WIDTH'(SHORT_NOMINAL);
    localparam logic [TIMER_WIDTH-1:0] LONG_T    = TIMER_WIDTH'(LONG_NOMINAL);
    localparam logic [TIMER_WIDTH-1:0] TOL_T     = TIMER_WIDTH'(TOLERANCE);
    localparam logic [TIMER_WIDTH-1:0] IDLE_T    = TIMER_WIDTH'(IDLE_TIMEOUT);
    localparam logic [BC_W-1:0]        LAST_BIT  = BC_W'(WORD_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   in_pulse_q;
    logic [TIMER_WIDTH-1:0] high_q, high_d;
    logic [TIMER_WIDTH-1:0] low_q, low_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic [BC_W-1:0]        bit_count_q, bit_count_d;
    logic [WORD_BITS-1:0]   word_data_q, word_data_d;
    logic                   word_valid_q, word_valid_d;
    logic                   pulse_error_q, pulse_error_d;
    logic                   timeout_q, timeout_d;
    logic                   overrun_q, overrun_d;

    logic                   s;
    logic                   rise;
    logic                   fall;
    logic                   idle_hit;
    logic                   handshake;
    logic [TIMER_WIDTH-1:0] d0, d1;
    logic                   ok0, ok1;
    logic                   accept;
    logic                   bit_val;

    assign s         = sync_q[SYNC_STAGES-1];
    assign rise      = s && !s_d_q;
    // A fall only measures a pulse whose rise was seen after reset.
    assign fall      = !s && s_d_q && in_pulse_q;
    assign handshake = word_valid_q && word_ready;

    // Pulse and idle timers: high timer restarts at 1 on a rise, both saturate.
    always_comb begin
        high_d = high_q;
        if (rise) begin
            high_d = TIMER_WIDTH'(1);
        end else if (s && high_q != TIMER_MAX) begin
            high_d = high_q + 1'b1;
        end
        if (s) begin
            low_d = '0;
        end else if (low_q != TIMER_MAX) begin
            low_d = low_q + 1'b1;
        end else begin
            low_d = low_q;
        end
    end

    // Only the transition onto IDLE_TIMEOUT counts, so a saturated timer cannot re-fire.
    assign idle_hit = (low_d == IDLE_T) && (low_q != IDLE_T);

    // Classify the measured width against both nominal values.
    always_comb begin
        d0      = (high_q >= SHORT_T) ? (high_q - SHORT_T) : (SHORT_T - high_q);
        d1      = (high_q >= LONG_T) ? (high_q - LONG_T) : (LONG_T - high_q);
        ok0     = (d0 <= TOL_T);
        ok1     = (d1 <= TOL_T);
        accept  = ok0 || ok1;
        // When both fit, the closer nominal wins and a tie resolves to 1.
        bit_val = (ok0 && ok1) ? !(d0 < d1) : ok1;
    end

    // Word assembly, output handshake and status flags.
    always_comb begin
        shift_d       = shift_q;
        bit_count_d   = bit_count_q;
        word_data_d   = word_data_q;
        word_valid_d  = word_valid_q;
        overrun_d     = overrun_q;
        pulse_error_d = 1'b0;
        timeout_d     = 1'b0;

        if (handshake) begin
            word_valid_d = 1'b0;
        end

        if (fall) begin
            if (!accept) begin
                pulse_error_d = 1'b1;
                shift_d       = '0;
                bit_count_d   = '0;
            end else begin
                shift_d = {shift_q[WORD_BITS-2:0], bit_val};
                if (bit_count_q == LAST_BIT) begin
                    bit_count_d = '0;
                    if (!word_valid_q || handshake) begin
                        word_data_d  = shift_d;
                        word_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    bit_count_d = bit_count_q + 1'b1;
                end
            end
        end else if (idle_hit && bit_count_q != '0) begin
            timeout_d   = 1'b1;
            shift_d     = '0;
            bit_count_d = '0;
        end
    end

    // State registers with synchronous reset; the line idles high inside the synchroniser.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q        <= '1;
            s_d_q         <= 1'b1;
            in_pulse_q    <= 1'b0;
            high_q        <= '0;
            low_q         <= '0;
            shift_q       <= '0;
            bit_count_q   <= '0;
            word_data_q   <= '0;
            word_valid_q  <= 1'b0;
            pulse_error_q <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], digital_in};
            s_d_q         <= s;
            if (rise) begin
                in_pulse_q <= 1'b1;
            end else if (!s && s_d_q) begin
                in_pulse_q <= 1'b0;
            end
            high_q        <= high_d;
            low_q         <= low_d;
            shift_q       <= shift_d;
            bit_count_q   <= bit_count_d;
            word_data_q   <= word_data_d;
            word_valid_q  <= word_valid_d;
            pulse_error_q <= pulse_error_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
        end
    end

    assign word_data   = word_data_q;
    assign word_valid  = word_valid_q;
    assign bit_count   = bit_count_q;
    assign pulse_error = pulse_error_q;
    assign timeout     = timeout_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Scoreboard bench for pulse_width_decoder.
// Stimulus pushes the expected words, errors and timeouts into a queue.
// A monitor pops an entry whenever the DUT shows a handshake, a pulse_error or a timeout.

module tb_pulse_width_decoder;

    localparam int EV_WORD    = 0;
    localparam int EV_ERROR   = 1;
    localparam int EV_TIMEOUT = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clock;
    logic       reset;
    logic       digital_in;
    logic [7:0] word_data;
    logic       word_valid;
    logic       word_ready;
    logic [3:0] bit_count;
    logic       pulse_error;
    logic       timeout;
    logic       overrun;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    pulse_width_decoder dut (
        .clock       (clock),
        .reset       (reset),
        .digital_in  (digital_in),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .bit_count   (bit_count),
        .pulse_error (pulse_error),
        .timeout     (timeout),
        .overrun     (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] data);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: got kind %0d data %02h at %0t, expected nothing", kind, data,
                     $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_WORD && e.data !== data)) begin
                fails++;
                $display("FAIL event: got kind %0d data %02h at %0t, expected kind %0d data %02h",
                         kind, data, $time, e.kind, e.data);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (pulse_error) observe(EV_ERROR, 8'h00);
            if (timeout) observe(EV_TIMEOUT, 8'h00);
            if (word_valid && word_ready) observe(EV_WORD, word_data);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // One high pulse then a low gap; optionally raise word_ready only in the fall-event cycle.
    task automatic send_pulse(input int high, input int low, input bit ready_on_fall);
        digital_in = 1'b1;
        repeat (high) step();
        digital_in = 1'b0;
        for (int i = 0; i < low; i++) begin
            if (ready_on_fall && i == 2) word_ready = 1'b1;
            if (ready_on_fall && i == 3) word_ready = 1'b0;
            step();
        end
    endtask

    task automatic send_word(input logic [7:0] w, input bit ready_on_last);
        for (int i = 7; i >= 0; i--) begin
            send_pulse(w[i] ? 18 : 9, 10, ready_on_last && i == 0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        digital_in = 1'b0;
        word_ready = 1'b1;
        step();
        do_reset();
        step();

        // Reset state.
        check("rst_word_data", 32'(word_data), 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_bit_count", 32'(bit_count), 32'h0);
        check("rst_pulse_error", 32'(pulse_error), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        // Nominal widths, 0 1 0 0 1 1 0 1.
        push(EV_WORD, 8'h4D);
        send_pulse(9, 10, 1'b0);
        send_pulse(18, 10, 1'b0);
        send_pulse(9, 10, 1'b0);
        send_pulse(9, 10, 1'b0);
        send_pulse(18, 10, 1'b0);
        send_pulse(18, 10, 1'b0);
        send_pulse(9, 10, 1'b0);
        send_pulse(18, 10, 1'b0);
        check("word_4d_valid_cleared", 32'(word_valid), 32'h0);
        check("word_4d_bit_count", 32'(bit_count), 32'h0);

        // Tolerance edges and rejects.
        send_pulse(13, 10, 1'b0);
        check("w13_bit_count", 32'(bit_count), 32'h1);
        send_pulse(14, 10, 1'b0);
        check("w14_bit_count", 32'(bit_count), 32'h2);
        check("w13_w14_bits", 32'(dut.shift_q[1:0]), 32'h1);
        push(EV_ERROR, 8'h00);
        send_pulse(4, 10, 1'b0);
        check("w4_bit_count", 32'(bit_count), 32'h0);
        push(EV_ERROR, 8'h00);
        send_pulse(23, 10, 1'b0);
        check("w23_bit_count", 32'(bit_count), 32'h0);
        push(EV_ERROR, 8'h00);
        digital_in = 1'b1;
        repeat (300) step();
        check("w300_high_saturated", 32'(dut.high_q), 32'd255);
        send_pulse(0, 10, 1'b0);
        check("w300_bit_count", 32'(bit_count), 32'h0);

        // Back-pressure: second word dropped, first held.
        word_ready = 1'b0;
        push(EV_WORD, 8'hA5);
        send_word(8'hA5, 1'b0);
        check("held_valid", 32'(word_valid), 32'h1);
        check("held_overrun_before", 32'(overrun), 32'h0);
        send_pulse(18, 10, 1'b0);
        check("held_data_mid", 32'(word_data), 32'hA5);
        send_word(8'h3C, 1'b0);
        check("held_data_after", 32'(word_data), 32'hA5);
        check("held_valid_after", 32'(word_valid), 32'h1);
        check("overrun_set", 32'(overrun), 32'h1);
        word_ready = 1'b1;
        step();
        step();
        check("overrun_sticky", 32'(overrun), 32'h1);
        check("held_drained", 32'(word_valid), 32'h0);

        do_reset();
        step();
        check("overrun_cleared_by_reset", 32'(overrun), 32'h0);

        // Handshake in the same cycle as a new word completes.
        word_ready = 1'b0;
        push(EV_WORD, 8'h5A);
        send_word(8'h5A, 1'b0);
        push(EV_WORD, 8'hE1);
        send_word(8'hE1, 1'b1);
        check("same_cycle_valid", 32'(word_valid), 32'h1);
        check("same_cycle_data", 32'(word_data), 32'hE1);
        check("same_cycle_overrun", 32'(overrun), 32'h0);
        word_ready = 1'b1;
        step();
        step();

        // Idle timeout on a partial word, then a clean word, then idle with nothing pending.
        send_pulse(18, 10, 1'b0);
        send_pulse(9, 10, 1'b0);
        check("partial_bit_count", 32'(bit_count), 32'h2);
        push(EV_TIMEOUT, 8'h00);
        send_pulse(18, 80, 1'b0);
        check("timeout_bit_count", 32'(bit_count), 32'h0);
        push(EV_WORD, 8'hC3);
        send_word(8'hC3, 1'b0);
        repeat (80) step();
        check("idle_no_timeout_bit_count", 32'(bit_count), 32'h0);
        check("queue_drained_before_reset", 32'(exp_q.size()), 32'h0);

        // Reset in the middle of a pulse.
        digital_in = 1'b1;
        repeat (10) step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        digital_in = 1'b0;
        repeat (20) step();
        check("midrst_word_data", 32'(word_data), 32'h0);
        check("midrst_word_valid", 32'(word_valid), 32'h0);
        check("midrst_bit_count", 32'(bit_count), 32'h0);
        check("midrst_overrun", 32'(overrun), 32'h0);
        push(EV_WORD, 8'h96);
        send_word(8'h96, 1'b0);
        repeat (20) step();

        check("queue_drained_final", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pulse_width_decoder.md
PULSE_WIDTH_DECODER -- requirements
Module: pulse_width_decoder

Interface
REQ-001 Parameter TIMER_WIDTH, default 8: width of the high-time and low-time counters.
REQ-002 Parameter SHORT_NOMINAL, default 9: nominal high time, in cycles, of a 0 bit.
REQ-003 Parameter LONG_NOMINAL, default 18: nominal high time, in cycles, of a 1 bit.
REQ-004 Parameter TOLERANCE, default 4: accepted deviation, in cycles, from either nominal value.
REQ-005 Parameter WORD_BITS, default 8: number of bits per output word.
REQ-006 Parameter IDLE_TIMEOUT, default 64: number of low cycles that aborts a partial word.
REQ-007 Parameter SYNC_STAGES, default 2 (minimum 2): input synchroniser depth.
REQ-008 clock  input  1  single clock; all logic on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 digital_in  input  1  asynchronous pulse-width-encoded serial line.
REQ-011 word_data  output  WORD_BITS  assembled word; the first received bit is the MSB.
REQ-012 word_valid  output  1  word_data holds an unconsumed word.
REQ-013 word_ready  input  1  consumer accepts the word when word_valid=1 and word_ready=1.
REQ-014 bit_count  output  $clog2(WORD_BITS)+1  number of bits held in the partial word.
REQ-015 pulse_error  output  1  one-cycle pulse: a pulse was rejected.
REQ-016 timeout  output  1  one-cycle pulse: a partial word was aborted by idle time.
REQ-017 overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-018 digital_in SHALL pass through SYNC_STAGES flops; the last stage is s, and s_d is s delayed by one cycle.
REQ-019 Rise event = s=1 and s_d=0; it SHALL set in_pulse=1 and load the high counter with 1.
REQ-020 While s=1 and there is no rise event, the high counter SHALL increment and saturate at 2^TIMER_WIDTH-1.
REQ-021 Fall event = s=0, s_d=1 and in_pulse=1; the measured width W is the high counter value, which equals the number of cycles s was high.
REQ-022 A fall event with in_pulse=0 SHALL be ignored; every fall event clears in_pulse.
REQ-023 Classification: d0=|W-SHORT_NOMINAL| and d1=|W-LONG_NOMINAL|, both computed unsigned without wrap.
  - Only d0<=TOLERANCE: bit 0.
  - Only d1<=TOLERANCE: bit 1.
  - Both within tolerance: bit 0 if d0<d1, else bit 1 (ties resolve to 1).
  - Neither within tolerance: rejected.
REQ-024 A rejected pulse SHALL assert pulse_error in the cycle after the fall event, discard the partial word and clear bit_count to 0.
REQ-025 An accepted bit SHALL shift in at the LSB of the assembly register, shifting toward the MSB, and increment bit_count; the update is visible the cycle after the fall event.
REQ-026 When bit_count would reach WORD_BITS:
  - The word SHALL load into word_data, with word_valid=1 in the cycle after the fall event, if word_valid=0 or the word is accepted in the same cycle.
  - Otherwise the word SHALL be dropped and overrun set.
  - In both cases bit_count SHALL return to 0.
REQ-027 word_data SHALL stay stable while word_valid=1 and word_ready=0; a handshake with no new word SHALL clear word_valid the next cycle.
REQ-028 overrun SHALL stay set until reset.
REQ-029 The low counter SHALL increment, saturating, while s=0, and SHALL clear while s=1.
REQ-030 In the cycle the low counter reaches IDLE_TIMEOUT with bit_count!=0, timeout SHALL pulse for one cycle and bit_count SHALL clear; with bit_count=0 there SHALL be no pulse.
REQ-031 Latency from the first clock edge that samples digital_in low to word_valid/pulse_error SHALL be SYNC_STAGES+1 cycles.

Reset
REQ-032 On reset, synchroniser stages and s_d SHALL be 1, and in_pulse, both counters, the assembly register, bit_count, word_data, word_valid, pulse_error, timeout and overrun SHALL be 0.
REQ-033 A pulse in progress across reset SHALL produce no bit and no error, because in_pulse=0.
REQ-034 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-035 Eight pulses of widths 9,18,9,9,18,18,9,18, each with 10 low cycles, word_ready=1 -> word_data=8'h4D, word_valid high for 1 cycle, pulse_error never set.
REQ-036 Widths 13 and 14 -> bits 0 and 1; widths 4, 23 and 300 -> pulse_error each time and bit_count=0; the 300-cycle pulse saturates the counter at 255.
REQ-037 word_ready=0 with two full words sent -> first word held stable with word_valid=1, second dropped, overrun=1 until reset; with word_ready=1 and a new word completing in the same cycle -> new word loaded, overrun=0.
REQ-038 Three bits followed by 64 low cycles -> timeout pulses once and bit_count=0; the next 8 pulses give a clean word; 64 low cycles with bit_count=0 -> no timeout.
REQ-039 Reset asserted mid-pulse, line held high 5 more cycles, then low -> no bit, no pulse_error, all outputs 0; subsequent pulses decode normally.
